// File: rtl/boot_loader.sv
// boot_loader: byte-stream loader that fills instruction memory, then releases the CPU reset.
//   Stream: 16-bit word count N (LSB first), N little-endian 32-bit words, optional checksum byte.
//   Macro BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in CSUM.
//   clk, rst (async, active-low); rx_valid/rx_data/rx_ready byte handshake;
//   imem_we/imem_addr/imem_wdata memory write port; cpu_rst, done, error status.
module boot_loader #(
    parameter int          MAX_WORDS = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);
`ifdef BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
    localparam state_t FIN = CSUM;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
    localparam state_t FIN = DONE;
`endif
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);
    state_t      state, state_d;
    logic [15:0] len, word_idx, n_full;
    logic [1:0]  byte_cnt;
    logic [31:0] shift, word;
    logic        acc, last_word;
    assign acc       = rx_valid & rx_ready;
    assign n_full    = {rx_data, len[7:0]};
    assign word      = {rx_data, shift[31:8]};
    assign last_word = word_idx == len - 16'd1;
    assign done      = state == DONE;
    assign error     = state == ERR;
    assign cpu_rst   = state != DONE;
    always_comb begin
        state_d = state;
        if (acc)
            case (state)
                LEN_LO:  state_d = LEN_HI;
                LEN_HI:  state_d = ({1'b0, n_full} > MAX_N) ? ERR : (n_full == 16'd0) ? FIN : DATA;
                DATA:    state_d = (byte_cnt == 2'd3 && last_word) ? FIN : DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
                CSUM:    state_d = (rx_data == csum) ? DONE : ERR;
`endif
                default: state_d = state;
            endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= LEN_LO;
        else      state <= state_d;
    // rx_ready is registered so it stays low in reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            rx_ready <= state_d != DONE && state_d != ERR;
            imem_we  <= 1'b0;
            if (acc && state == LEN_LO) len[7:0] <= rx_data;
            if (acc && state == LEN_HI) len[15:8] <= rx_data;
            if (acc && state == DATA) begin
                shift    <= word;
                byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
                if (byte_cnt == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                    imem_wdata <= word;
                    word_idx   <= word_idx + 16'd1;
                end
            end
        end
endmodule
